// File: rtl/pixel_serializer.sv
// pixel_serializer: buffers fetched video words and shifts them out MSB-first as BPP-bit pixels, one per DIV clocks.
// Latency: a word pushed into an empty FIFO with enable high shows its first pixel two clocks after it is offered.
// Backpressure: load_ready drops while the word FIFO holds FIFO_DEPTH words; an empty FIFO at a word boundary flags underrun.

// Small synchronous word FIFO: registered level, no read bypass, flush empties it.
module pixel_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [W-1:0]               data_i,
  input  logic                       pop_i,
  output logic [W-1:0]               data_o,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH) + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [LW-1:0] level_q;
  logic          push_ok;
  logic          pop_ok;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  // A flush wins over any push or pop offered in the same cycle.
  assign push_ok = push_i && !full_o && !flush_i;
  assign pop_ok  = pop_i && !empty_o && !flush_i;
  assign data_o  = mem_q[rd_ptr_q];
  assign level_o = level_q;

  // Storage array: written on accepted pushes only, contents need no reset.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two; level tracks occupancy.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

module pixel_serializer #(
  parameter int             DATA_WIDTH = 8,
  parameter int             BPP        = 1,
  parameter int             DIV        = 2,
  parameter int             FIFO_DEPTH = 2,
  parameter logic [BPP-1:0] IDLE_PIXEL = {BPP{1'b1}}
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          line_flush,
  input  logic                          load_valid,
  input  logic [DATA_WIDTH-1:0]         load_data,
  output logic                          load_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [BPP-1:0]                pixel,
  output logic                          pixel_valid,
  output logic                          pixel_tick,
  output logic                          underrun
);

  localparam int NPIX = DATA_WIDTH / BPP;
  localparam int CW   = $clog2(NPIX + 1);
  localparam int DVW  = (DIV > 1) ? $clog2(DIV) : 1;
  // An empty shifter holds idle pixels so the output mux is just the top slice.
  localparam logic [DATA_WIDTH-1:0] IDLE_WORD = {NPIX{IDLE_PIXEL}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PRIME  = 2'd1,
    ST_ACTIVE = 2'd2
  } state_e;

  state_e                state_q;
  state_e                state_d;
  logic [DATA_WIDTH-1:0] shreg_q;
  logic [DATA_WIDTH-1:0] shreg_d;
  logic [CW-1:0]         remain_q;
  logic [CW-1:0]         remain_d;
  logic [DVW-1:0]        div_q;
  logic [DVW-1:0]        div_d;
  logic                  valid_q;
  logic                  valid_d;
  logic                  tick_q;
  logic                  tick_d;
  logic                  underrun_q;
  logic                  underrun_d;

  logic                  fifo_pop;
  logic [DATA_WIDTH-1:0] fifo_dat;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  div_last;
  logic                  last_pixel;

  pixel_fifo #(
    .W     (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (reset),
    .flush_i (line_flush),
    .push_i  (load_valid),
    .data_i  (load_data),
    .pop_i   (fifo_pop),
    .data_o  (fifo_dat),
    .level_o (fifo_level),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign load_ready  = !fifo_full;
  assign div_last    = (div_q == DVW'(DIV - 1));
  assign last_pixel  = (remain_q <= CW'(1));

  assign pixel       = shreg_q[DATA_WIDTH-1 -: BPP];
  assign pixel_valid = valid_q;
  assign pixel_tick  = tick_q;
  assign underrun    = underrun_q;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: flush, then enable, then the normal IDLE/PRIME/ACTIVE progression.
  always_comb begin
    state_d = state_q;
    if (line_flush) begin
      state_d = enable ? ST_PRIME : ST_IDLE;
    end else if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        // Enable high with an empty shifter behaves as PRIME straight away.
        ST_IDLE, ST_PRIME: begin
          state_d = fifo_empty ? ST_PRIME : ST_ACTIVE;
        end
        ST_ACTIVE: begin
          if (div_last && last_pixel && fifo_empty) begin
            state_d = ST_PRIME;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Datapath and output next values: shifter, pixel counter, divider, flags, FIFO pop.
  always_comb begin
    shreg_d    = shreg_q;
    remain_d   = remain_q;
    div_d      = div_q;
    valid_d    = valid_q;
    tick_d     = 1'b0;
    underrun_d = underrun_q;
    fifo_pop   = 1'b0;
    if (line_flush) begin
      shreg_d    = IDLE_WORD;
      remain_d   = '0;
      div_d      = '0;
      valid_d    = 1'b0;
      underrun_d = 1'b0;
    end else if (!enable) begin
      // Line inactive: drop the current word, park the divider, keep the FIFO.
      shreg_d  = IDLE_WORD;
      remain_d = '0;
      div_d    = '0;
      valid_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_PRIME: begin
          div_d = '0;
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shreg_d  = fifo_dat;
            remain_d = CW'(NPIX);
            valid_d  = 1'b1;
            tick_d   = 1'b1;
          end else begin
            // Waiting for the first word of a line is not an underrun.
            shreg_d  = IDLE_WORD;
            remain_d = '0;
            valid_d  = 1'b0;
          end
        end
        ST_ACTIVE: begin
          if (!div_last) begin
            div_d = div_q + DVW'(1);
          end else begin
            div_d = '0;
            if (!last_pixel) begin
              shreg_d  = (shreg_q << BPP) | DATA_WIDTH'(IDLE_PIXEL);
              remain_d = remain_q - CW'(1);
              tick_d   = 1'b1;
            end else if (!fifo_empty) begin
              // Reload on the same edge so the next word follows with no gap.
              fifo_pop = 1'b1;
              shreg_d  = fifo_dat;
              remain_d = CW'(NPIX);
              tick_d   = 1'b1;
            end else begin
              underrun_d = 1'b1;
              shreg_d    = IDLE_WORD;
              remain_d   = '0;
              valid_d    = 1'b0;
            end
          end
        end
        default: begin
          shreg_d  = IDLE_WORD;
          remain_d = '0;
          div_d    = '0;
          valid_d  = 1'b0;
        end
      endcase
    end
  end

  // Datapath registers; reset leaves the shifter full of idle pixels.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg_q    <= IDLE_WORD;
      remain_q   <= '0;
      div_q      <= '0;
      valid_q    <= 1'b0;
      tick_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      shreg_q    <= shreg_d;
      remain_q   <= remain_d;
      div_q      <= div_d;
      valid_q    <= valid_d;
      tick_q     <= tick_d;
      underrun_q <= underrun_d;
    end
  end

endmodule

// File: tb/tb_pixel_serializer.sv
// Bench for pixel_serializer: default instance (8-bit, 1 bpp, DIV 2, depth 2) and a 2 bpp / DIV 3 instance.
// Expected pixels come from a queue filled by splitting each accepted word MSB-first.
// Timing and flag expectations are written directly from the block's described behaviour.
module tb_pixel_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic       en_a, flush_a, lv_a;
  logic [7:0] ld_a;
  logic       rdy_a;
  logic [1:0] lvl_a;
  logic [0:0] pix_a;
  logic       pv_a, pt_a, ur_a;

  logic       en_b, flush_b, lv_b;
  logic [7:0] ld_b;
  logic       rdy_b;
  logic [1:0] lvl_b;
  logic [1:0] pix_b;
  logic       pv_b, pt_b, ur_b;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q[$];

  pixel_serializer dut_a (
    .clk(clk), .reset(reset), .enable(en_a), .line_flush(flush_a),
    .load_valid(lv_a), .load_data(ld_a), .load_ready(rdy_a), .fifo_level(lvl_a),
    .pixel(pix_a), .pixel_valid(pv_a), .pixel_tick(pt_a), .underrun(ur_a)
  );

  pixel_serializer #(.DATA_WIDTH(8), .BPP(2), .DIV(3), .FIFO_DEPTH(2)) dut_b (
    .clk(clk), .reset(reset), .enable(en_b), .line_flush(flush_b),
    .load_valid(lv_b), .load_data(ld_b), .load_ready(rdy_b), .fifo_level(lvl_b),
    .pixel(pix_b), .pixel_valid(pv_b), .pixel_tick(pt_b), .underrun(ur_b)
  );

  // Reference: a word becomes 8/bpp pixels, most significant first.
  task automatic model_push(input logic [7:0] w, input int bpp);
    for (int p = 8 / bpp - 1; p >= 0; p--) begin
      exp_q.push_back(int'((w >> (p * bpp)) & ((1 << bpp) - 1)));
    end
  endtask

  task automatic flush_a_pulse(input logic en);
    @(negedge clk);
    en_a = en; flush_a = 1'b1;
    @(negedge clk);
    flush_a = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    en_a = 0; flush_a = 0; lv_a = 0; ld_a = '0;
    en_b = 0; flush_b = 0; lv_b = 0; ld_b = '0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({pix_a, pv_a, pt_a, ur_a} !== 4'b1000) begin
      n_fail++; $display("FAIL reset_pix_a: got pix/valid/tick/underrun=%b expected 1000", {pix_a, pv_a, pt_a, ur_a});
    end
    n_checks++;
    if ({lvl_a, rdy_a} !== 3'b001) begin
      n_fail++; $display("FAIL reset_fifo_a: got level=%0d ready=%b expected level=0 ready=1", lvl_a, rdy_a);
    end
    n_checks++;
    if ({pix_b, pv_b, pt_b, ur_b, lvl_b, rdy_b} !== 8'b11000001) begin
      n_fail++; $display("FAIL reset_b: got %b expected 11000001", {pix_b, pv_b, pt_b, ur_b, lvl_b, rdy_b});
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_a5_3c;
    exp_q.delete();
    model_push(8'hA5, 1);
    model_push(8'h3C, 1);
    @(negedge clk); en_a = 1'b1;
    @(negedge clk); lv_a = 1'b1; ld_a = 8'hA5;
    @(negedge clk); ld_a = 8'h3C;
    @(negedge clk); lv_a = 1'b0;
    n_checks++;
    if (pt_a !== 1'b1) begin
      n_fail++; $display("FAIL first_pixel_latency: got tick=%b expected 1", pt_a);
    end
    for (int i = 0; i < 32; i++) begin
      n_checks++;
      if (pix_a !== exp_q[i / 2][0] || pv_a !== 1'b1 || pt_a !== (i % 2 == 0)) begin
        n_fail++;
        $display("FAIL a5_3c_cycle%0d: got pix=%b valid=%b tick=%b expected pix=%0d valid=1 tick=%b",
                 i, pix_a, pv_a, pt_a, exp_q[i / 2], (i % 2 == 0));
      end
      @(negedge clk);
    end
    n_checks++;
    if ({ur_a, pix_a, pv_a, pt_a} !== 4'b1100) begin
      n_fail++; $display("FAIL a5_3c_underrun: got underrun/pix/valid/tick=%b expected 1100", {ur_a, pix_a, pv_a, pt_a});
    end
  endtask

  task automatic test_fifo_full;
    logic [7:0] w0, w1, w2;
    int got;
    w0 = 8'($urandom); w1 = 8'($urandom); w2 = 8'($urandom);
    flush_a_pulse(1'b0);
    n_checks++;
    if (ur_a !== 1'b0) begin
      n_fail++; $display("FAIL flush_clears_underrun: got %b expected 0", ur_a);
    end
    lv_a = 1'b1; ld_a = w0;
    @(negedge clk);
    n_checks++;
    if (lvl_a !== 2'd1 || rdy_a !== 1'b1) begin
      n_fail++; $display("FAIL full_one: got level=%0d ready=%b expected 1/1", lvl_a, rdy_a);
    end
    ld_a = w1;
    @(negedge clk);
    n_checks++;
    if (lvl_a !== 2'd2 || rdy_a !== 1'b0) begin
      n_fail++; $display("FAIL full_two: got level=%0d ready=%b expected 2/0", lvl_a, rdy_a);
    end
    ld_a = w2;
    @(negedge clk);
    n_checks++;
    if (lvl_a !== 2'd2 || rdy_a !== 1'b0 || pv_a !== 1'b0) begin
      n_fail++; $display("FAIL full_third_refused: got level=%0d ready=%b valid=%b expected 2/0/0", lvl_a, rdy_a, pv_a);
    end
    lv_a = 1'b0;
    exp_q.delete();
    model_push(w0, 1);
    model_push(w1, 1);
    en_a = 1'b1;
    got = 0;
    for (int c = 0; c < 200 && got < 16; c++) begin
      @(negedge clk);
      if (pt_a) begin
        n_checks++;
        if (pix_a !== exp_q[0][0] || pv_a !== 1'b1) begin
          n_fail++; $display("FAIL prefill_pixel%0d: got pix=%b valid=%b expected pix=%0d valid=1", got, pix_a, pv_a, exp_q[0]);
        end
        void'(exp_q.pop_front());
        got++;
      end
    end
    n_checks++;
    if (got !== 16) begin
      n_fail++; $display("FAIL prefill_count: got %0d ticks expected 16", got);
    end
    repeat (4) @(negedge clk);
    n_checks++;
    if ({ur_a, pv_a, lvl_a} !== 4'b1000) begin
      n_fail++; $display("FAIL prefill_drained: got underrun=%b valid=%b level=%0d expected 1/0/0", ur_a, pv_a, lvl_a);
    end
  endtask

  task automatic test_bpp2_div3;
    logic [7:0] words [2];
    words[0] = 8'hE4;
    words[1] = 8'($urandom);
    @(negedge clk); en_b = 1'b1;
    for (int k = 0; k < 2; k++) begin
      exp_q.delete();
      model_push(words[k], 2);
      @(negedge clk); lv_b = 1'b1; ld_b = words[k];
      @(negedge clk); lv_b = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 12; i++) begin
        n_checks++;
        if (pix_b !== 2'(exp_q[i / 3]) || pv_b !== 1'b1 || pt_b !== (i % 3 == 0)) begin
          n_fail++;
          $display("FAIL bpp2_word%0d_cycle%0d: got pix=%0d valid=%b tick=%b expected pix=%0d valid=1 tick=%b",
                   k, i, pix_b, pv_b, pt_b, exp_q[i / 3], (i % 3 == 0));
        end
        @(negedge clk);
      end
      n_checks++;
      if ({ur_b, pix_b, pv_b} !== 4'b1110) begin
        n_fail++; $display("FAIL bpp2_word%0d_end: got underrun/pix/valid=%b expected 1110", k, {ur_b, pix_b, pv_b});
      end
    end
  endtask

  task automatic test_stream;
    int sent, got, last;
    logic [7:0] w;
    flush_a_pulse(1'b1);
    exp_q.delete();
    sent = 0; got = 0; last = 0;
    for (int c = 0; c < 3000 && got < 512; c++) begin
      @(negedge clk);
      if (pt_a) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL stream_extra_tick: got tick with no pixel expected");
        end else begin
          if (pix_a !== exp_q[0][0] || pv_a !== 1'b1 || (got > 0 && c - last != 2)) begin
            n_fail++; $display("FAIL stream_pixel%0d: got pix=%b valid=%b spacing=%0d expected pix=%0d valid=1 spacing=2",
                               got, pix_a, pv_a, c - last, exp_q[0]);
          end
          void'(exp_q.pop_front());
        end
        last = c;
        got++;
      end
      if (sent < 64) begin
        w = 8'($urandom);
        lv_a = 1'b1; ld_a = w;
        if (rdy_a) begin
          model_push(w, 1);
          sent++;
        end
      end else begin
        lv_a = 1'b0;
      end
    end
    lv_a = 1'b0;
    n_checks++;
    if (got !== 512 || ur_a !== 1'b0) begin
      n_fail++; $display("FAIL stream_total: got %0d pixels underrun=%b expected 512 pixels underrun=0", got, ur_a);
    end
  endtask

  task automatic test_random_gaps;
    int sent, got;
    logic [7:0] w;
    flush_a_pulse(1'b1);
    exp_q.delete();
    sent = 0; got = 0;
    for (int c = 0; c < 8000 && (sent < 40 || exp_q.size() > 0); c++) begin
      @(negedge clk);
      if (pt_a) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL gaps_extra_tick: got tick with no pixel expected");
        end else begin
          if (pix_a !== exp_q[0][0] || pv_a !== 1'b1) begin
            n_fail++; $display("FAIL gaps_pixel%0d: got pix=%b valid=%b expected pix=%0d valid=1", got, pix_a, pv_a, exp_q[0]);
          end
          void'(exp_q.pop_front());
        end
        got++;
      end
      lv_a = 1'b0;
      if (sent < 40 && $urandom_range(0, 11) == 0) begin
        w = 8'($urandom);
        lv_a = 1'b1; ld_a = w;
        if (rdy_a) begin
          model_push(w, 1);
          sent++;
        end
      end
    end
    lv_a = 1'b0;
    n_checks++;
    if (got !== 8 * sent || exp_q.size() != 0) begin
      n_fail++; $display("FAIL gaps_total: got %0d pixels expected %0d", got, 8 * sent);
    end
  endtask

  task automatic test_enable_drop;
    logic [7:0] w0, w1;
    int got, ticks;
    w0 = 8'($urandom); w1 = 8'($urandom);
    flush_a_pulse(1'b1);
    @(negedge clk); lv_a = 1'b1; ld_a = w0;
    @(negedge clk); ld_a = w1;
    @(negedge clk); lv_a = 1'b0;
    repeat (5) @(negedge clk);
    en_a = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({pix_a, pv_a, pt_a, lvl_a} !== 5'b10001) begin
      n_fail++; $display("FAIL enable_drop: got pix/valid/tick=%b level=%0d expected 100 level=1", {pix_a, pv_a, pt_a}, lvl_a);
    end
    ticks = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (pt_a || pv_a) ticks++;
    end
    n_checks++;
    if (ticks !== 0) begin
      n_fail++; $display("FAIL enable_low_quiet: got %0d active cycles expected 0", ticks);
    end
    exp_q.delete();
    model_push(w1, 1);
    en_a = 1'b1;
    got = 0;
    for (int c = 0; c < 100 && got < 8; c++) begin
      @(negedge clk);
      if (pt_a) begin
        n_checks++;
        if (pix_a !== exp_q[0][0]) begin
          n_fail++; $display("FAIL reenable_pixel%0d: got %b expected %0d", got, pix_a, exp_q[0]);
        end
        void'(exp_q.pop_front());
        got++;
      end
    end
    n_checks++;
    if (got !== 8) begin
      n_fail++; $display("FAIL reenable_count: got %0d ticks expected 8", got);
    end
  endtask

  task automatic test_flush;
    int busy;
    repeat (4) @(negedge clk);
    n_checks++;
    if (ur_a !== 1'b1) begin
      n_fail++; $display("FAIL pre_flush_underrun: got %b expected 1", ur_a);
    end
    lv_a = 1'b1; ld_a = 8'($urandom);
    @(negedge clk); lv_a = 1'b0;
    repeat (7) @(negedge clk);
    n_checks++;
    if (ur_a !== 1'b1 || pv_a !== 1'b1) begin
      n_fail++; $display("FAIL underrun_sticky: got underrun=%b valid=%b expected 1/1", ur_a, pv_a);
    end
    flush_a = 1'b1; lv_a = 1'b1; ld_a = 8'($urandom);
    @(negedge clk);
    flush_a = 1'b0; lv_a = 1'b0;
    n_checks++;
    if ({lvl_a, ur_a, pix_a, pv_a, pt_a} !== 6'b000100) begin
      n_fail++; $display("FAIL flush_state: got level=%0d underrun=%b pix=%b valid=%b tick=%b expected 0/0/1/0/0",
                         lvl_a, ur_a, pix_a, pv_a, pt_a);
    end
    busy = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (pt_a || pv_a || lvl_a != 2'd0) busy++;
    end
    n_checks++;
    if (busy !== 0) begin
      n_fail++; $display("FAIL flush_push_dropped: got %0d busy cycles expected 0", busy);
    end
  endtask

  task automatic test_async_reset;
    int got;
    lv_a = 1'b1; ld_a = 8'($urandom);
    @(negedge clk); lv_a = 1'b0;
    repeat (20) @(negedge clk);
    lv_a = 1'b1; ld_a = 8'($urandom);
    @(negedge clk); lv_a = 1'b0;
    repeat (6) @(negedge clk);
    n_checks++;
    if (ur_a !== 1'b1 || pv_a !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset_state: got underrun=%b valid=%b expected 1/1", ur_a, pv_a);
    end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if ({pix_a, pv_a, pt_a, ur_a, lvl_a, rdy_a} !== 7'b1000001) begin
      n_fail++; $display("FAIL async_reset: got %b expected 1000001", {pix_a, pv_a, pt_a, ur_a, lvl_a, rdy_a});
    end
    @(negedge clk);
    reset = 1'b0;
    lv_a = 1'b1; ld_a = 8'hFF;
    @(negedge clk); lv_a = 1'b0;
    got = 0;
    for (int c = 0; c < 100 && got < 8; c++) begin
      @(negedge clk);
      if (pt_a) begin
        n_checks++;
        if (pix_a !== 1'b1 || pv_a !== 1'b1) begin
          n_fail++; $display("FAIL ff_pixel%0d: got pix=%b valid=%b expected 1/1", got, pix_a, pv_a);
        end
        got++;
      end
    end
    n_checks++;
    if (got !== 8) begin
      n_fail++; $display("FAIL ff_count: got %0d ticks expected 8", got);
    end
  endtask

  initial begin
    test_reset();
    test_a5_3c();
    test_fifo_full();
    test_bpp2_div3();
    test_stream();
    test_random_gaps();
    test_enable_drop();
    test_flush();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete within the time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
